// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: feeds queued {slave, byte} commands to the SPI master one transfer at a time and returns the received bytes in order.
// Latency: ~12 clk from command pop to response for a normal transfer, 3+TIMEOUT worst case, 2 clk for an invalid id.
// Backpressure: cmd_ready drops while the command FIFO is full; launches stall while the response FIFO is full.

module spi_txn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module spi_txn_scheduler #(
    parameter int CMD_DEPTH    = 4,
    parameter int RSP_DEPTH    = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_slave,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_slave,
    output logic       rsp_err,
    output logic       start,
    output logic [1:0] slaveSelect,
    output logic [7:0] masterDataToSend,
    input  logic [7:0] masterDataReceived,
    input  logic [0:2] CS,
    output logic       busy
);
    typedef struct packed {
        logic [1:0] slave;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] slave;
        logic       err;
    } rsp_t;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT_DONE, CAPTURE, ERR} state_t;

    localparam int PW = $clog2(START_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    cmd_t          cmd_in;
    cmd_t          cmd_head;
    rsp_t          rsp_wr;
    rsp_t          rsp_head;
    logic          cmd_full;
    logic          cmd_empty;
    logic          rsp_full;
    logic          rsp_empty;
    logic          cmd_pop;
    logic          rsp_push;
    logic [1:0]    hold_slave;
    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] tmo_cnt;

    assign cmd_in.slave = cmd_slave;
    assign cmd_in.data  = cmd_data;

    spi_txn_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (cmd_valid),
        .wr_dat (cmd_in),
        .rd_rdy (cmd_pop),
        .rd_dat (cmd_head),
        .full   (cmd_full),
        .empty  (cmd_empty)
    );

    spi_txn_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (rsp_push),
        .wr_dat (rsp_wr),
        .rd_rdy (rsp_ready),
        .rd_dat (rsp_head),
        .full   (rsp_full),
        .empty  (rsp_empty)
    );

    assign cmd_ready = !cmd_full;
    assign rsp_valid = !rsp_empty;
    // Head storage is undefined when empty, so the outputs are masked to zero.
    assign rsp_data  = rsp_valid ? rsp_head.data  : 8'h00;
    assign rsp_slave = rsp_valid ? rsp_head.slave : 2'b00;
    assign rsp_err   = rsp_valid ? rsp_head.err   : 1'b0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_wr    = '0;
        case (state)
            IDLE: begin
                if (!cmd_empty && !rsp_full) begin
                    cmd_pop   = 1'b1;
                    state_nxt = (cmd_head.slave == 2'd3) ? ERR : SETUP;
                end
            end
            SETUP: state_nxt = PULSE;
            PULSE: begin
                if (pulse_cnt == PW'(START_CYCLES - 1)) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (CS == 3'b111)                  state_nxt = CAPTURE;
                else if (tmo_cnt >= TW'(TIMEOUT)) state_nxt = ERR;
            end
            CAPTURE: begin
                rsp_push     = 1'b1;
                rsp_wr.data  = masterDataReceived;
                rsp_wr.slave = hold_slave;
                rsp_wr.err   = 1'b0;
                state_nxt    = IDLE;
            end
            ERR: begin
                rsp_push     = 1'b1;
                rsp_wr.data  = 8'h00;
                rsp_wr.slave = hold_slave;
                rsp_wr.err   = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            start            <= 1'b0;
            slaveSelect      <= 2'b11;
            masterDataToSend <= 8'h00;
            hold_slave       <= 2'b00;
            pulse_cnt        <= '0;
            tmo_cnt          <= '0;
        end else begin
            state <= state_nxt;
            start <= (state_nxt == PULSE);
            if (cmd_pop) hold_slave <= cmd_head.slave;
            // Loaded at the pop edge so the master sees stable data for the whole SETUP cycle.
            if (cmd_pop && state_nxt == SETUP) begin
                slaveSelect      <= cmd_head.slave;
                masterDataToSend <= cmd_head.data;
            end
            if (state == PULSE) pulse_cnt <= pulse_cnt + 1'b1;
            else                pulse_cnt <= '0;
            if (state_nxt == PULSE && state != PULSE)
                tmo_cnt <= '0;
            else if ((state == PULSE || state == WAIT_DONE) && tmo_cnt != TW'(TIMEOUT))
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
endmodule
